// File: rtl/ts_sync_aligner_pkg.sv
// ts_sync_aligner_pkg: shared TS framing constants, aligner state encoding and helpers
package ts_sync_aligner_pkg;
  localparam int TS_PKT_LEN = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int TS_LOCK_THRESH = 5;
  localparam int TS_UNLOCK_THRESH = 2;
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} ts_state_e;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner: MPEG-2 TS sync-byte hunter/aligner with 5-in/2-out lock hysteresis
module ts_sync_aligner
  import ts_sync_aligner_pkg::*;
#(
  parameter int PKT_LEN = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
  parameter int LOCK_THRESH = TS_LOCK_THRESH,
  parameter int UNLOCK_THRESH = TS_UNLOCK_THRESH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       clr_count,
  output logic       valid,
  output logic       sync,
  output logic [7:0] ts_data,
  output logic       locked,
  output logic [7:0] sync_loss_count
);
  localparam int PW = $clog2(PKT_LEN);
  localparam int GW = $clog2(LOCK_THRESH + 1);
  localparam int BW = $clog2(UNLOCK_THRESH + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_THRESH);
  localparam logic [BW-1:0] BAD_DROP = BW'(UNLOCK_THRESH);
  ts_state_e state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, pos_inc;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [BW-1:0] bad_q, bad_d, bad_inc;
  logic valid_q, valid_d, sync_q, sync_d, locked_q, locked_d;
  logic [7:0] data_q, data_d, cnt_q, cnt_d;
  logic is_sync, boundary, loss;
  assign is_sync = in_data == SYNC_BYTE;
  assign boundary = pos_q == '0;
  assign pos_inc = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
  assign good_inc = good_q + 1'b1;
  assign bad_inc = bad_q + 1'b1;
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    good_d = good_q;
    bad_d = bad_q;
    locked_d = locked_q;
    valid_d = 1'b0;
    sync_d = 1'b0;
    loss = 1'b0;
    data_d = in_valid ? in_data : data_q;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d = VERIFY;
            pos_d = PW'(1);
            good_d = GW'(1);
          end
        end
        VERIFY: begin
          pos_d = pos_inc;
          if (boundary && is_sync) begin
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) begin
              state_d = LOCKED;
              locked_d = 1'b1;
              valid_d = 1'b1;
              sync_d = 1'b1;
              bad_d = '0;
            end
          end else if (boundary) begin
            state_d = HUNT;
            pos_d = '0;
            good_d = '0;
          end
        end
        LOCKED: begin
          pos_d = pos_inc;
          valid_d = 1'b1;
          sync_d = boundary;
          if (boundary) bad_d = is_sync ? '0 : bad_inc;
          if (boundary && !is_sync && bad_inc == BAD_DROP) begin
            state_d = HUNT;
            pos_d = '0;
            good_d = '0;
            bad_d = '0;
            locked_d = 1'b0;
            valid_d = 1'b0;
            sync_d = 1'b0;
            loss = 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
          pos_d = '0;
          good_d = '0;
          bad_d = '0;
          locked_d = 1'b0;
        end
      endcase
    end
    cnt_d = clr_count ? '0 : loss ? sat_inc8(cnt_q) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      pos_q <= '0;
      good_q <= '0;
      bad_q <= '0;
      valid_q <= 1'b0;
      sync_q <= 1'b0;
      locked_q <= 1'b0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      good_q <= good_d;
      bad_q <= bad_d;
      valid_q <= valid_d;
      sync_q <= sync_d;
      locked_q <= locked_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
  assign valid = valid_q;
  assign sync = sync_q;
  assign ts_data = data_q;
  assign locked = locked_q;
  assign sync_loss_count = cnt_q;
endmodule

// File: tb/tb_ts_sync_aligner.sv
// tb_ts_sync_aligner: directed self-checking bench for ts_sync_aligner
module tb_ts_sync_aligner;
  import ts_sync_aligner_pkg::*;
  localparam int PKT = TS_PKT_LEN;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic clr_count = 1'b0;
  logic [7:0] in_data = '0;
  logic valid, sync, locked;
  logic [7:0] ts_data, sync_loss_count;
  logic in2_valid = 1'b0;
  logic [7:0] in2_data = '0;
  logic valid2, sync2, locked2;
  logic [7:0] ts_data2, cnt2;
  int n_chk = 0, n_fail = 0;
  int n_valid, n_sync, idle_err, tot;
  logic f_valid, f_sync;
  logic [7:0] f_data;
  always #5 clk = ~clk;
  ts_sync_aligner dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clr_count(clr_count),
    .valid(valid), .sync(sync), .ts_data(ts_data), .locked(locked), .sync_loss_count(sync_loss_count)
  );
  ts_sync_aligner #(.PKT_LEN(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in2_valid), .in_data(in2_data), .clr_count(1'b0),
    .valid(valid2), .sync(sync2), .ts_data(ts_data2), .locked(locked2), .sync_loss_count(cnt2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk);
    #1;
    n_valid += int'(valid);
    n_sync += int'(sync);
  endtask
  task automatic idle(input int n);
    logic [7:0] held;
    held = ts_data;
    in_valid = 1'b0;
    in_data = 8'h47;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (valid || sync || ts_data !== held) idle_err++;
    end
  endtask
  task automatic send_pkt(input logic [7:0] sb, input bit gaps, input bit clr0);
    n_valid = 0;
    n_sync = 0;
    if (gaps) idle(2);
    clr_count = clr0;
    send_byte(sb);
    clr_count = 1'b0;
    f_valid = valid;
    f_sync = sync;
    f_data = ts_data;
    for (int i = 1; i < PKT; i++) begin
      if (gaps && i % 23 == 0) idle($urandom_range(1, 4));
      send_byte(8'h80 | 8'(i));
    end
  endtask
  task automatic relock();
    tot = 0;
    repeat (4) begin
      send_pkt(8'h47, 0, 0);
      tot += n_valid;
    end
    chk("relock_pre_valid", tot, 0);
    chk("relock_pre_locked", locked, 0);
    send_pkt(8'h47, 0, 0);
    chk("relock_sync", f_sync, 1);
    chk("relock_locked", locked, 1);
  endtask
  task automatic pkt2(input logic [7:0] sb);
    for (int i = 0; i < 4; i++) begin
      in2_valid = 1'b1;
      in2_data = (i == 0) ? sb : 8'h80 | 8'(i);
      @(posedge clk);
      #1;
    end
    in2_valid = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_sync", sync, 0);
    chk("rst_locked", locked, 0);
    chk("rst_data", ts_data, 0);
    chk("rst_count", sync_loss_count, 0);
    @(negedge clk);
    reset = 1'b0;
    tot = 0;
    for (int p = 0; p < 4; p++) begin
      send_pkt(8'h47, 0, 0);
      tot += n_valid;
    end
    chk("hunt_verify_valid", tot, 0);
    chk("prelock_locked", locked, 0);
    send_pkt(8'h47, 0, 0);
    chk("lock_first_valid", f_valid, 1);
    chk("lock_first_sync", f_sync, 1);
    chk("lock_first_data", f_data, 8'h47);
    chk("lock_locked", locked, 1);
    chk("lock_nvalid", n_valid, PKT);
    chk("lock_nsync", n_sync, 1);
    idle_err = 0;
    send_pkt(8'h47, 1, 0);
    chk("gap_nvalid", n_valid, PKT);
    chk("gap_nsync", n_sync, 1);
    chk("gap_first_sync", f_sync, 1);
    chk("gap_idle_quiet", idle_err, 0);
    chk("gap_count", sync_loss_count, 0);
    send_pkt(8'h00, 0, 0);
    chk("bad1_valid", f_valid, 1);
    chk("bad1_sync", f_sync, 1);
    chk("bad1_data", f_data, 8'h00);
    chk("bad1_locked", locked, 1);
    chk("bad1_count", sync_loss_count, 0);
    send_pkt(8'h47, 0, 0);
    send_pkt(8'h00, 0, 0);
    chk("badclr_sync", f_sync, 1);
    chk("badclr_locked", locked, 1);
    send_pkt(8'h00, 0, 0);
    chk("loss_valid", f_valid, 0);
    chk("loss_nvalid", n_valid, 0);
    chk("loss_locked", locked, 0);
    chk("loss_count", sync_loss_count, 1);
    relock();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h47);
    for (int i = 1; i < 10; i++) send_byte(8'h80 | 8'(i));
    tot = 0;
    for (int p = 0; p < 5; p++) begin
      send_pkt(8'h47, 0, 0);
      tot += n_valid;
    end
    chk("false_pre_valid", tot, 0);
    chk("false_pre_locked", locked, 0);
    send_pkt(8'h47, 0, 0);
    chk("false_lock_sync", f_sync, 1);
    chk("false_lock_nsync", n_sync, 1);
    chk("false_locked", locked, 1);
    send_pkt(8'h00, 0, 0);
    send_pkt(8'h00, 0, 0);
    chk("clr_pre_count", sync_loss_count, 1);
    relock();
    send_pkt(8'h00, 0, 0);
    send_pkt(8'h00, 0, 1);
    chk("clr_win_count", sync_loss_count, 0);
    chk("clr_win_locked", locked, 0);
    relock();
    send_pkt(8'h00, 0, 0);
    send_pkt(8'h00, 0, 0);
    chk("post_clr_count", sync_loss_count, 1);
    relock();
    send_byte(8'h47);
    for (int i = 1; i < 50; i++) send_byte(8'h80 | 8'(i));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_sync", sync, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_data", ts_data, 0);
    chk("mid_rst_count", sync_loss_count, 0);
    @(negedge clk);
    reset = 1'b0;
    n_valid = 0;
    for (int i = 50; i < PKT; i++) send_byte(8'h80 | 8'(i));
    chk("post_rst_tail_valid", n_valid, 0);
    relock();
    in_valid = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      repeat (5) pkt2(8'h47);
      repeat (2) pkt2(8'h00);
      if (k == 1) chk("sat_first", cnt2, 1);
      if (k == 254) chk("sat_fe", cnt2, 8'hFE);
      if (k == 255) chk("sat_ff", cnt2, 8'hFF);
    end
    chk("sat_hold", cnt2, 8'hFF);
    chk("sat_unlocked", locked2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
